// File: rtl/w_rom_fetch_ctrl.sv
// w_rom_fetch_ctrl: burst reader for the banked weight ROM.
// Realigns fixed-latency ROM data into a small FIFO feeding a valid/ready stream.
module w_rom_fetch_ctrl #(
    parameter int DATA_WIDTH  = 4608,
    parameter int DATA_DEPTH  = 1024,
    parameter int ROM_LATENCY = 1,
    parameter int FIFO_DEPTH  = 2,
    localparam int ADDR_WIDTH = $clog2(DATA_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_b,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   num_words,
    output logic                  busy,
    output logic                  done,
    output logic                  rom_r_en,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic                  wt_valid,
    input  logic                  wt_ready,
    output logic [DATA_WIDTH-1:0] wt_data,
    output logic                  wt_last
);

    localparam int NW = ADDR_WIDTH + 1;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + ROM_LATENCY + 1) + 1;

    if (ROM_LATENCY < 1 || ROM_LATENCY > 4) begin : g_bad_lat
        $error("w_rom_fetch_ctrl: ROM_LATENCY must be 1..4");
    end
    if (FIFO_DEPTH < ROM_LATENCY + 1) begin : g_bad_depth
        $error("w_rom_fetch_ctrl: FIFO_DEPTH must be >= ROM_LATENCY+1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [NW-1:0]           remain_q, remain_d;
    logic [ROM_LATENCY-1:0]  pipe_vld_q;
    logic [ROM_LATENCY-1:0]  pipe_last_q;
    logic [DATA_WIDTH-1:0]   mem_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]   last_q;
    logic [PW-1:0]           wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]           cnt_q;

    logic [CW-1:0] inflight;
    logic          pop;
    logic          push;
    logic          push_last;
    logic          space;
    logic          issue;
    logic          issue_last;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        inflight = '0;
        for (int i = 0; i < ROM_LATENCY; i++) begin
            inflight = inflight + CW'(pipe_vld_q[i]);
        end
    end

    assign wt_valid   = (cnt_q != '0);
    assign wt_data    = mem_q[rd_ptr_q];
    assign wt_last    = wt_valid & last_q[rd_ptr_q];
    assign pop        = wt_valid & wt_ready;
    assign push       = pipe_vld_q[ROM_LATENCY-1];
    assign push_last  = pipe_last_q[ROM_LATENCY-1];

    // Reads in flight already own a FIFO slot, so a pop this cycle frees one.
    assign space      = (cnt_q + inflight - CW'(pop)) < CW'(FIFO_DEPTH);
    assign issue      = (state_q == S_FETCH) && space;
    assign issue_last = issue && (remain_q == NW'(1));

    assign rom_r_en = ~issue;
    assign rom_addr = addr_q;
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d   = base_addr;
                    remain_d = num_words;
                    state_d  = (num_words == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                if (issue) begin
                    addr_d   = addr_q + 1'b1;
                    remain_d = remain_q - 1'b1;
                    if (issue_last) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (pop && wt_last) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            remain_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            remain_q <= remain_d;
        end
    end

    // Alignment pipe: one {valid,last} slot per cycle of ROM latency.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            pipe_vld_q  <= '0;
            pipe_last_q <= '0;
        end else begin
            pipe_vld_q[0]  <= issue;
            pipe_last_q[0] <= issue_last;
            for (int i = 1; i < ROM_LATENCY; i++) begin
                pipe_vld_q[i]  <= pipe_vld_q[i-1];
                pipe_last_q[i] <= pipe_last_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            last_q   <= '0;
        end else begin
            if (push) begin
                wr_ptr_q         <= ptr_inc(wr_ptr_q);
                last_q[wr_ptr_q] <= push_last;
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            cnt_q <= cnt_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= rom_data;
        end
    end

endmodule

// File: tb/tb_w_rom_fetch_ctrl.sv
// Bench for w_rom_fetch_ctrl: burst table plus random backpressure,
// checked against a transaction-level model of issued and consumed words.
module tb_w_rom_fetch_ctrl;

    localparam int DW    = 4608;
    localparam int DEPTH = 1024;
    localparam int AW    = 10;
    localparam int NW    = AW + 1;
    localparam int LAT   = 1;
    localparam int FD    = 2;
    localparam int LAT6  = 3;
    localparam int FD6   = 4;

    logic clk = 1'b0;
    logic rst_b = 1'b0;
    always #5 clk = ~clk;

    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [NW-1:0] num_words = '0;
    logic          wt_ready = 1'b0;
    logic          busy, done, rom_r_en, wt_valid, wt_last;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data, wt_data;

    logic          start6 = 1'b0;
    logic [AW-1:0] base6 = '0;
    logic [NW-1:0] num6 = NW'(DEPTH);
    logic          ready6 = 1'b0;
    logic          busy6, done6, rom_r_en6, wt_valid6, wt_last6;
    logic [AW-1:0] rom_addr6;
    logic [DW-1:0] rom_data6, wt_data6;

    int total = 0;
    int bad = 0;

    function automatic logic [DW-1:0] word(input int a);
        logic [DW-1:0] w;
        logic [31:0]   h;
        h = (32'(a) * 32'h9E37_79B1) ^ 32'h5EED_1234;
        for (int i = 0; i < DW / 32; i++) begin
            w[i*32 +: 32] = h + 32'(i);
        end
        return w;
    endfunction

    w_rom_fetch_ctrl #(
        .DATA_WIDTH(DW), .DATA_DEPTH(DEPTH),
        .ROM_LATENCY(LAT), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rst_b(rst_b), .start(start),
        .base_addr(base_addr), .num_words(num_words),
        .busy(busy), .done(done), .rom_r_en(rom_r_en),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .wt_valid(wt_valid), .wt_ready(wt_ready),
        .wt_data(wt_data), .wt_last(wt_last)
    );

    w_rom_fetch_ctrl #(
        .DATA_WIDTH(DW), .DATA_DEPTH(DEPTH),
        .ROM_LATENCY(LAT6), .FIFO_DEPTH(FD6)
    ) dut6 (
        .clk(clk), .rst_b(rst_b), .start(start6),
        .base_addr(base6), .num_words(num6),
        .busy(busy6), .done(done6), .rom_r_en(rom_r_en6),
        .rom_addr(rom_addr6), .rom_data(rom_data6),
        .wt_valid(wt_valid6), .wt_ready(ready6),
        .wt_data(wt_data6), .wt_last(wt_last6)
    );

    // ROM models: data appears exactly LAT cycles after a sampled read.
    logic [DW-1:0] rq;
    logic [DW-1:0] r6 [LAT6];
    always @(posedge clk) begin
        rq    <= rom_r_en ? '1 : word(int'(rom_addr));
        r6[0] <= rom_r_en6 ? '1 : word(int'(rom_addr6));
        for (int i = 1; i < LAT6; i++) r6[i] <= r6[i-1];
    end
    assign rom_data  = rq;
    assign rom_data6 = r6[LAT6-1];

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic chkw(input string nm, input logic [DW-1:0] got,
                        input logic [DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got[31:0]=%h exp[31:0]=%h",
                     nm, got[31:0], exp[31:0]);
        end
    endtask

    // Transaction model: a burst is n words at base+i; a word is
    // consumable LAT+1 cycles after its read; at most FD words may be
    // outstanding (issued but not consumed) after this cycle's pop.
    int cyc = 0;
    bit m_busy = 0, m_done = 0, m_done_nx = 0;
    int m_base = 0, m_n = 0, m_iss = 0, m_pop = 0, m_avail = 0;
    int m_start_cyc = 0, m_done_cyc = 0, last_iss = -1;
    int issq[$];

    task automatic model_reset();
        m_busy = 0; m_done = 0; m_done_nx = 0;
        m_n = 0; m_iss = 0; m_pop = 0; m_avail = 0;
        issq.delete();
    endtask

    task automatic check_cycle();
        bit ev, ern, pop;
        int outst;
        #1;
        while (m_avail < issq.size() && issq[m_avail] + LAT + 1 <= cyc)
            m_avail++;
        ev    = (m_avail > m_pop);
        pop   = ev && wt_ready;
        outst = m_iss - m_pop - (pop ? 1 : 0);
        ern   = !(m_busy && !m_done && m_iss < m_n && outst < FD);
        chk("busy", busy, m_busy);
        chk("done", done, m_done);
        chk("wt_valid", wt_valid, ev);
        chk("rom_r_en", rom_r_en, ern);
        if (ev) begin
            chkw("head_data", wt_data, word((m_base + m_pop) % DEPTH));
            chk("head_last", wt_last, m_pop == m_n - 1);
        end
        if (!ern) begin
            chk("rom_addr", rom_addr, (m_base + m_iss) % DEPTH);
            issq.push_back(cyc);
            last_iss = (m_base + m_iss) % DEPTH;
            m_iss++;
        end
        if (pop) begin
            if (m_pop == m_n - 1) m_done_nx = 1;
            m_pop++;
        end
        if (m_done) m_done_cyc = cyc;
        if (start && !m_busy) begin
            m_busy = 1;
            m_base = int'(base_addr);
            m_n = int'(num_words);
            m_iss = 0; m_pop = 0; m_avail = 0;
            issq.delete();
            m_start_cyc = cyc;
            last_iss = -1;
            if (num_words == '0) m_done_nx = 1;
        end else if (m_done) begin
            m_busy = 0;
        end
        m_done = m_done_nx;
        m_done_nx = 0;
        cyc++;
    endtask

    task automatic tick(input bit st, input int b, input int n,
                        input bit rdy);
        @(negedge clk);
        start = st;
        base_addr = AW'(b);
        num_words = NW'(n);
        wt_ready = rdy;
        check_cycle();
    endtask

    typedef struct {
        int base;
        int n;
        int rmode;
        int exp_lat;
        int exp_last;
    } vec_t;

    task automatic run_burst(input vec_t v, input int abort_iss);
        int  k;
        bit  rdy;
        tick(1, v.base, v.n, 1);
        for (k = 0; k < 4000; k++) begin
            if (v.rmode == 0) rdy = 1;
            else if (k < 4) rdy = (k == 0 || k == 3);
            else rdy = 1'($urandom_range(0, 1));
            // A start while busy must be ignored.
            if (k == 0) tick(1, 32'h0AA, 3, rdy);
            else tick(0, 0, 0, rdy);
            if (abort_iss > 0 && m_iss >= abort_iss) return;
            if (!m_busy) break;
        end
        chk("burst_timeout", k >= 4000, 0);
        chk("words_popped", m_pop, v.n);
        if (v.exp_lat >= 0)
            chk("done_latency", m_done_cyc - m_start_cyc, v.exp_lat);
        if (v.n > 0) chk("last_addr", last_iss, v.exp_last);
    endtask

    task automatic reset_check();
        #2;
        start = 0;
        rst_b = 0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_r_en", rom_r_en, 1);
        chk("rst_addr", rom_addr, 0);
        chk("rst_valid", wt_valid, 0);
        chk("rst_last", wt_last, 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_b = 1;
    endtask

    task automatic run_t6();
        int c, pops, iss, first, lastc, dcyc, derr, aerr, lerr;
        c = 0; pops = 0; iss = 0; first = -1; lastc = -1; dcyc = -1;
        derr = 0; aerr = 0; lerr = 0;
        @(negedge clk);
        start6 = 1;
        ready6 = 1;
        while (dcyc < 0 && c < 3000) begin
            @(negedge clk);
            start6 = 0;
            c++;
            #1;
            if (!rom_r_en6) begin
                if (int'(rom_addr6) != iss % DEPTH) aerr++;
                iss++;
            end
            if (wt_valid6 && ready6) begin
                if (pops == 0) first = c;
                if (wt_data6 !== word(pops % DEPTH)) derr++;
                if (wt_last6 !== (pops == DEPTH - 1)) lerr++;
                lastc = c;
                pops++;
            end
            if (done6) dcyc = c;
        end
        chk("t6_issued", iss, DEPTH);
        chk("t6_popped", pops, DEPTH);
        chk("t6_addr_errs", aerr, 0);
        chk("t6_data_errs", derr, 0);
        chk("t6_last_errs", lerr, 0);
        chk("t6_first_valid", first, LAT6 + 2);
        chk("t6_span", lastc - first, DEPTH - 1);
        chk("t6_done_after_last", dcyc - lastc, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[6];
        vec_t v;
        tbl[0] = '{32'h010, 4, 0, 7, 32'h013};
        tbl[1] = '{32'h3FE, 4, 0, 7, 32'h001};
        tbl[2] = '{32'h123, 1, 0, 4, 32'h123};
        tbl[3] = '{32'h055, 8, 1, -1, 32'h05C};
        tbl[4] = '{32'h200, 0, 0, 1, -1};
        tbl[5] = '{32'h3FF, 5, 1, -1, 32'h003};

        #3;
        chk("init_busy", busy, 0);
        chk("init_r_en", rom_r_en, 1);
        chk("init_addr", rom_addr, 0);
        chk("init_valid", wt_valid, 0);
        chk("init_done", done, 0);
        @(negedge clk);
        rst_b = 1;

        for (int i = 0; i < 6; i++) run_burst(tbl[i], 0);

        v = '{32'h100, 8, 0, -1, 32'h107};
        run_burst(v, 3);
        reset_check();
        v = '{32'h300, 6, 0, 9, 32'h305};
        run_burst(v, 0);

        for (int i = 0; i < 4; i++) begin
            v.base = int'($urandom_range(0, DEPTH - 1));
            v.n = int'($urandom_range(1, 12));
            v.rmode = 1;
            v.exp_lat = -1;
            v.exp_last = (v.base + v.n - 1) % DEPTH;
            run_burst(v, 0);
        end

        run_t6();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
